// File: rtl/hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_pkg
// Shared types and constants for the pipeline hazard / fetch-miss controller.
//   fwd_sel_t      : per-source forwarding select (regfile, WB result, MEM value)
//   refill_state_t : I-cache refill sequencer states
//   X0_ADDR        : hard-wired zero register, never forwarded or hazarded on
// -----------------------------------------------------------------------------
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10,
        FILL = 2'b11
    } refill_state_t;

    localparam logic [31:0] X0_ADDR = 32'd0;

endpackage

// File: rtl/hazard_ctrl_fwd.sv
// -----------------------------------------------------------------------------
// fwd_sel_unit
// Single-source forwarding comparator. Picks the youngest in-flight producer of
// the execute-stage source register; the MEM stage is younger than WB and so
// wins when both match. Register x0 is never forwarded.
// Ports:
//   rs_addr      in  source register address in execute
//   rd_addr_mem  in  destination in memory stage
//   rd_addr_wb   in  destination in write-back stage
//   reg_we_mem   in  memory-stage register write enable
//   reg_we_wb    in  write-back register write enable
//   sel          out forwarding select (fwd_sel_t)
// -----------------------------------------------------------------------------
module fwd_sel_unit
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] rs_addr,
    input  logic [REG_ADDR_W-1:0] rd_addr_mem,
    input  logic [REG_ADDR_W-1:0] rd_addr_wb,
    input  logic                  reg_we_mem,
    input  logic                  reg_we_wb,
    output fwd_sel_t              sel
);

    localparam logic [REG_ADDR_W-1:0] X0_LOC = REG_ADDR_W'(X0_ADDR);

    logic rs_nonzero_s;

    // Priority compare: MEM first, then WB, otherwise read the register file.
    always_comb begin
        sel          = FWD_RF;
        rs_nonzero_s = (rs_addr != X0_LOC);
        if (reg_we_mem && (rd_addr_mem == rs_addr) && rs_nonzero_s) begin
            sel = FWD_MEM;
        end else if (reg_we_wb && (rd_addr_wb == rs_addr) && rs_nonzero_s) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_RF;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard and fetch-miss controller for the 5-stage core.
//   - Forwarding selects for NUM_SRC execute-stage source operands.
//   - Load-use detection against the decode-stage sources.
//   - I-cache refill sequencer (IDLE -> REQ -> WAIT -> FILL) with an AXI
//     request handshake and a saturating, sticky refill watchdog.
// All hazard outputs are combinational from the sequencer state and the
// inputs; every output reads 0 while i_arst is asserted.
// Optional build macro HAZARD_PERF_CNT_EN adds three saturating 32-bit
// performance counters (stall cycles, refill starts, redirect flushes).
// Ports:
//   i_clk, i_arst            clock, asynchronous active-high reset
//   i_rs_addr_dec/_exec      NUM_SRC packed source addresses (decode/execute)
//   i_rd_addr_exec/_mem/_wb  destination addresses per stage
//   i_reg_we_mem/_wb         register write enables
//   i_load_instr_exec        execute holds a load
//   i_pc_src_exec            taken redirect resolved in execute
//   i_icache_hit             fetch hits the I-cache
//   i_axi_ready/_done        AXI request accepted / refill block available
//   o_stall_fetch/_dec       hold PC / fetch-decode register
//   o_flush_dec/_exec        inject bubbles
//   o_forward                2 bits per source (00 RF, 01 WB, 10 MEM)
//   o_axi_start, o_instr_we  refill request valid / I-cache write
//   o_refill_timeout         sticky watchdog error
//   o_perf_*                 (HAZARD_PERF_CNT_EN only) performance counters
// -----------------------------------------------------------------------------
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int NUM_SRC    = 2,
    parameter int TIMEOUT_W  = 8
) (
    input  logic                          i_clk,
    input  logic                          i_arst,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] i_rs_addr_dec,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] i_rs_addr_exec,
    input  logic [REG_ADDR_W-1:0]         i_rd_addr_exec,
    input  logic [REG_ADDR_W-1:0]         i_rd_addr_mem,
    input  logic [REG_ADDR_W-1:0]         i_rd_addr_wb,
    input  logic                          i_reg_we_mem,
    input  logic                          i_reg_we_wb,
    input  logic                          i_load_instr_exec,
    input  logic                          i_pc_src_exec,
    input  logic                          i_icache_hit,
    input  logic                          i_axi_ready,
    input  logic                          i_axi_done,
    output logic                          o_stall_fetch,
    output logic                          o_stall_dec,
    output logic                          o_flush_dec,
    output logic                          o_flush_exec,
    output logic [2*NUM_SRC-1:0]          o_forward,
    output logic                          o_axi_start,
    output logic                          o_instr_we,
    output logic                          o_refill_timeout
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]                   o_perf_stall_cyc,
    output logic [31:0]                   o_perf_miss_cnt,
    output logic [31:0]                   o_perf_flush_cnt
`endif
);

    localparam logic [REG_ADDR_W-1:0] X0_LOC = REG_ADDR_W'(X0_ADDR);
    localparam logic [TIMEOUT_W-1:0]  WD_MAX = {TIMEOUT_W{1'b1}};
    localparam logic [TIMEOUT_W-1:0]  WD_ONE = TIMEOUT_W'(1);

    refill_state_t          state_r;
    refill_state_t          state_s;
    logic [TIMEOUT_W-1:0]   wd_r;
    logic [TIMEOUT_W-1:0]   wd_s;
    logic                   timeout_r;

    fwd_sel_t               fwd_sel_s [NUM_SRC];
    logic                   any_match_s;
    logic                   lu_s;
    logic                   miss_req_s;
    logic                   miss_stall_s;
    logic                   stall_raw_s;
    logic                   flush_raw_s;

    // One forwarding comparator per execute-stage source operand.
    for (genvar k = 0; k < NUM_SRC; k++) begin : g_fwd
        fwd_sel_unit #(
            .REG_ADDR_W (REG_ADDR_W)
        ) u_fwd (
            .rs_addr     (i_rs_addr_exec[k*REG_ADDR_W +: REG_ADDR_W]),
            .rd_addr_mem (i_rd_addr_mem),
            .rd_addr_wb  (i_rd_addr_wb),
            .reg_we_mem  (i_reg_we_mem),
            .reg_we_wb   (i_reg_we_wb),
            .sel         (fwd_sel_s[k])
        );
    end

    // Load-use and miss detection; a redirect suppresses a new refill request.
    always_comb begin
        any_match_s = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            any_match_s = any_match_s |
                (i_rs_addr_dec[k*REG_ADDR_W +: REG_ADDR_W] == i_rd_addr_exec);
        end
        lu_s         = i_load_instr_exec && (i_rd_addr_exec != X0_LOC) && any_match_s;
        miss_req_s   = !i_icache_hit && !i_pc_src_exec;
        miss_stall_s = (state_r != IDLE) || miss_req_s;
        stall_raw_s  = (lu_s || miss_stall_s) && !i_pc_src_exec;
        flush_raw_s  = i_pc_src_exec;
    end

    // Refill sequencer next state; a redirect outside IDLE cannot occur and is ignored.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (miss_req_s) state_s = REQ;
                else            state_s = IDLE;
            end
            REQ: begin
                if (i_axi_ready && i_axi_done) state_s = FILL;
                else if (i_axi_ready)          state_s = WAIT;
                else                           state_s = REQ;
            end
            WAIT: begin
                if (i_axi_done) state_s = FILL;
                else            state_s = WAIT;
            end
            FILL:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Watchdog counts the cycle it is in, so it reads N during the Nth REQ/WAIT cycle.
    always_comb begin
        if ((state_s == REQ) || (state_s == WAIT)) begin
            if (wd_r == WD_MAX) wd_s = WD_MAX;
            else                wd_s = wd_r + WD_ONE;
        end else begin
            wd_s = {TIMEOUT_W{1'b0}};
        end
    end

    // Sequencer state, watchdog counter and sticky timeout flag.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state_r   <= IDLE;
            wd_r      <= {TIMEOUT_W{1'b0}};
            timeout_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            wd_r      <= wd_s;
            timeout_r <= timeout_r | (wd_r == WD_MAX);
        end
    end

    // Output drive; everything is forced low while reset is held.
    always_comb begin
        o_stall_fetch    = 1'b0;
        o_stall_dec      = 1'b0;
        o_flush_dec      = 1'b0;
        o_flush_exec     = 1'b0;
        o_forward        = {(2*NUM_SRC){1'b0}};
        o_axi_start      = 1'b0;
        o_instr_we       = 1'b0;
        o_refill_timeout = 1'b0;
        if (!i_arst) begin
            o_stall_fetch    = stall_raw_s;
            o_stall_dec      = stall_raw_s;
            o_flush_dec      = flush_raw_s;
            o_flush_exec     = i_pc_src_exec || lu_s || miss_stall_s;
            for (int k = 0; k < NUM_SRC; k++) begin
                o_forward[2*k +: 2] = fwd_sel_s[k];
            end
            o_axi_start      = (state_r == REQ);
            o_instr_we       = (state_r == FILL);
            // The saturating cycle itself already reports the timeout.
            o_refill_timeout = timeout_r || (wd_r == WD_MAX);
        end else begin
            o_stall_fetch    = 1'b0;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    logic [31:0] perf_stall_r;
    logic [31:0] perf_miss_r;
    logic [31:0] perf_flush_r;

    // Saturating performance counters.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            perf_stall_r <= 32'd0;
            perf_miss_r  <= 32'd0;
            perf_flush_r <= 32'd0;
        end else begin
            if (stall_raw_s && (perf_stall_r != CNT_MAX)) begin
                perf_stall_r <= perf_stall_r + 32'd1;
            end
            if ((state_r == IDLE) && (state_s == REQ) && (perf_miss_r != CNT_MAX)) begin
                perf_miss_r <= perf_miss_r + 32'd1;
            end
            if (flush_raw_s && (perf_flush_r != CNT_MAX)) begin
                perf_flush_r <= perf_flush_r + 32'd1;
            end
        end
    end

    assign o_perf_stall_cyc = perf_stall_r;
    assign o_perf_miss_cnt  = perf_miss_r;
    assign o_perf_flush_cnt = perf_flush_r;
`endif

endmodule
